traffic_light_ctrl_param: RTL and testbench

Parametrised adaptive traffic-light controller for NUM_LANES approaches served round-robin. It generalises the fixed four-lane FSM with programmable cycle-count timers for primary green, extension, yellow and all-red clearance. A congestion sensor can grant up to MAX_EXT repeated extensions. It sits between the per-lane start/congestion sensor front end and the lamp driver decoder.

---
 rtl/traffic_light_ctrl_param_if.sv | 45 ++++
 rtl/traffic_light_ctrl_param.sv | 184 ++++++++++++++++++
 tb/tb_traffic_light_ctrl_param.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_param_if.sv
// rtl/traffic_light_ctrl_param_if.sv - sensor and lamp bundle for the parametrised traffic-light controller
//
// Ports (signals in the bundle):
//   start_sense   per-lane vehicle-present sensor      (master -> slave)
//   cong_sense    per-lane congestion sensor           (master -> slave)
//   phase         0=SCAN 1=GREEN 2=EXT 3=YELLOW 4=ALLRED (slave -> master)
//   active_lane   lane being scanned or served         (slave -> master)
//   light_signal  0=all red, 2*lane+1 green, 2*lane+2 yellow
//   green_onehot  one-hot green lamp
//   yellow_onehot one-hot yellow lamp
//   timer         remaining cycles in timed phase minus 1
//   ext_cnt       extensions granted in current green
//   cycle_done    one-cycle pulse on lane wrap to 0
interface traffic_light_ctrl_param_if #(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 8,
    parameter int MAX_EXT   = 2
);
    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int SIG_W  = $clog2(2 * NUM_LANES + 1);
    localparam int EXT_W  = ($clog2(MAX_EXT + 1) < 1) ? 1 : $clog2(MAX_EXT + 1);

    logic [NUM_LANES-1:0] start_sense;
    logic [NUM_LANES-1:0] cong_sense;
    logic [2:0]           phase;
    logic [LANE_W-1:0]    active_lane;
    logic [SIG_W-1:0]     light_signal;
    logic [NUM_LANES-1:0] green_onehot;
    logic [NUM_LANES-1:0] yellow_onehot;
    logic [CNT_W-1:0]     timer;
    logic [EXT_W-1:0]     ext_cnt;
    logic                 cycle_done;

    modport master (
        output start_sense, cong_sense,
        input  phase, active_lane, light_signal, green_onehot, yellow_onehot,
               timer, ext_cnt, cycle_done
    );

    modport slave (
        input  start_sense, cong_sense,
        output phase, active_lane, light_signal, green_onehot, yellow_onehot,
               timer, ext_cnt, cycle_done
    );
endinterface

// File: rtl/traffic_light_ctrl_param.sv
// rtl/traffic_light_ctrl_param.sv - round-robin adaptive traffic-light controller with extension timers
//
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    slave side of traffic_light_ctrl_param_if (sensors in, phase/lamps/timer out)
//
// Lanes are scanned one per cycle; a lane with its start sensor set gets a
// green of GREEN_T cycles, optionally extended up to MAX_EXT times by EXT_T
// while its congestion sensor is high at the end of each green/extension,
// then YELLOW_T of yellow and ALLRED_T of all-red before scanning resumes
// at the next lane.
module traffic_light_ctrl_param #(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_T   = 4,
    parameter int EXT_T     = 2,
    parameter int MAX_EXT   = 2,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    traffic_light_ctrl_param_if.slave     bus
);
    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int SIG_W  = $clog2(2 * NUM_LANES + 1);
    localparam int EXT_W  = ($clog2(MAX_EXT + 1) < 1) ? 1 : $clog2(MAX_EXT + 1);

    // Timer reload values: a phase of N cycles starts at N-1 and ends at 0.
    localparam logic [CNT_W-1:0]  GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0]  EXT_LD    = CNT_W'(EXT_T - 1);
    localparam logic [CNT_W-1:0]  YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0]  ALLRED_LD = CNT_W'((ALLRED_T > 0) ? ALLRED_T - 1 : 0);
    localparam logic [EXT_W-1:0]  MAX_EXT_V = EXT_W'(MAX_EXT);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

    typedef enum logic [2:0] {
        PH_SCAN   = 3'd0,
        PH_GREEN  = 3'd1,
        PH_EXT    = 3'd2,
        PH_YELLOW = 3'd3,
        PH_ALLRED = 3'd4
    } phase_t;

    phase_t            phase_q, phase_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [EXT_W-1:0]  ext_q, ext_d;
    logic              cd_q, cd_d;
    logic              lane_ok;
    logic              lane_wrap;
    logic [LANE_W-1:0] lane_next;
    logic [SIG_W-1:0]  lane_x;

    // Compared one bit wider so the check stays meaningful when NUM_LANES
    // fills the lane register exactly.
    assign lane_ok   = ({1'b0, lane_q} <= (LANE_W + 1)'(NUM_LANES - 1));
    assign lane_wrap = (lane_q == LANE_LAST);
    assign lane_next = lane_wrap ? '0 : lane_q + LANE_W'(1);
    assign lane_x    = SIG_W'(lane_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_SCAN;
            lane_q  <= '0;
            timer_q <= '0;
            ext_q   <= '0;
            cd_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            lane_q  <= lane_d;
            timer_q <= timer_d;
            ext_q   <= ext_d;
            cd_q    <= cd_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        lane_d  = lane_q;
        timer_d = timer_q;
        ext_d   = ext_q;
        cd_d    = 1'b0;

        if (!lane_ok) begin
            phase_d = PH_SCAN;
            lane_d  = '0;
            timer_d = '0;
            ext_d   = '0;
        end else begin
            case (phase_q)
                PH_SCAN: begin
                    if (bus.start_sense[lane_q]) begin
                        phase_d = PH_GREEN;
                        timer_d = GREEN_LD;
                        ext_d   = '0;
                    end else begin
                        lane_d = lane_next;
                        cd_d   = lane_wrap;
                    end
                end
                PH_GREEN: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else if (bus.cong_sense[lane_q] && (MAX_EXT > 0)) begin
                        phase_d = PH_EXT;
                        timer_d = EXT_LD;
                        ext_d   = EXT_W'(1);
                    end else begin
                        phase_d = PH_YELLOW;
                        timer_d = YELLOW_LD;
                    end
                end
                PH_EXT: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else if (bus.cong_sense[lane_q] && (ext_q < MAX_EXT_V)) begin
                        timer_d = EXT_LD;
                        ext_d   = ext_q + EXT_W'(1);
                    end else begin
                        phase_d = PH_YELLOW;
                        timer_d = YELLOW_LD;
                    end
                end
                PH_YELLOW: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else if (ALLRED_T > 0) begin
                        phase_d = PH_ALLRED;
                        timer_d = ALLRED_LD;
                    end else begin
                        phase_d = PH_SCAN;
                        timer_d = '0;
                        lane_d  = lane_next;
                        cd_d    = lane_wrap;
                    end
                end
                PH_ALLRED: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else begin
                        phase_d = PH_SCAN;
                        timer_d = '0;
                        lane_d  = lane_next;
                        cd_d    = lane_wrap;
                    end
                end
                default: begin
                    phase_d = PH_SCAN;
                    lane_d  = '0;
                    timer_d = '0;
                    ext_d   = '0;
                end
            endcase
        end
    end

    // Lamp decode from registered state only; an illegal state shows all red.
    always_comb begin
        bus.light_signal  = '0;
        bus.green_onehot  = '0;
        bus.yellow_onehot = '0;
        if (lane_ok) begin
            case (phase_q)
                PH_GREEN, PH_EXT: begin
                    bus.light_signal = (lane_x << 1) + SIG_W'(1);
                    bus.green_onehot = NUM_LANES'(1) << lane_q;
                end
                PH_YELLOW: begin
                    bus.light_signal  = (lane_x << 1) + SIG_W'(2);
                    bus.yellow_onehot = NUM_LANES'(1) << lane_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.phase       = phase_q;
    assign bus.active_lane = lane_q;
    assign bus.timer       = timer_q;
    assign bus.ext_cnt     = ext_q;
    assign bus.cycle_done  = cd_q;
endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// tb/tb_traffic_light_ctrl_param.sv - self-checking bench for traffic_light_ctrl_param
module tb_traffic_light_ctrl_param;
    localparam int NL = 4;
    localparam int GT = 4;
    localparam int ET = 2;
    localparam int MX = 2;
    localparam int YT = 2;
    localparam int AT = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    traffic_light_ctrl_param_if #(.NUM_LANES(4), .CNT_W(8), .MAX_EXT(2)) bus ();
    traffic_light_ctrl_param_if #(.NUM_LANES(3), .CNT_W(8), .MAX_EXT(0)) bus3 ();

    traffic_light_ctrl_param #(
        .NUM_LANES(4), .CNT_W(8), .GREEN_T(GT), .EXT_T(ET),
        .MAX_EXT(MX), .YELLOW_T(YT), .ALLRED_T(AT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    traffic_light_ctrl_param #(
        .NUM_LANES(3), .CNT_W(8), .GREEN_T(4), .EXT_T(2),
        .MAX_EXT(0), .YELLOW_T(2), .ALLRED_T(0)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit       rst_n;
        bit [3:0] start;
        bit [3:0] cong;
        int       ph;
        int       lane;
        int       light;
        int       timer;
        int       ext;
        int       cd;
    } vec_t;

    vec_t tbl[32];

    // Expected one-hot lamps follow from the lamp code itself.
    function automatic logic [27:0] pack_exp(int ph, int lane, int light, int timer, int ext, int cd);
        int g, y;
        g = (light % 2 == 1) ? (1 << ((light - 1) / 2)) : 0;
        y = (light != 0 && light % 2 == 0) ? (1 << ((light - 2) / 2)) : 0;
        return {3'(ph), 2'(lane), 4'(light), 4'(g), 4'(y), 8'(timer), 2'(ext), 1'(cd)};
    endfunction

    function automatic logic [27:0] pack_act();
        return {bus.phase, bus.active_lane, bus.light_signal, bus.green_onehot,
                bus.yellow_onehot, bus.timer, bus.ext_cnt, bus.cycle_done};
    endfunction

    task automatic check(input string name, input logic [27:0] exp);
        logic [27:0] act;
        act = pack_act();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {ph,lane,sig,g,y,tmr,ext,cd}=%h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic step(input bit r, input logic [3:0] s, input logic [3:0] c);
        rst_n = r;
        bus.start_sense = s;
        bus.cong_sense  = c;
        @(posedge clk);
        #1;
    endtask

    // Timeline reference model: a served lane owns a window of cycles counted
    // from its first green cycle; the window is green, then yellow, then
    // all-red, and the green part grows by ET whenever an extension is granted.
    bit m_serving;
    int m_lane, m_el, m_glen, m_ext, m_cd;

    task automatic model_step(input bit r, input logic [3:0] s, input logic [3:0] c);
        if (!r) begin
            m_serving = 0; m_lane = 0; m_el = 0; m_ext = 0; m_cd = 0;
            return;
        end
        m_cd = 0;
        if (!m_serving) begin
            if (s[m_lane]) begin
                m_serving = 1; m_el = 0; m_glen = GT; m_ext = 0;
            end else begin
                m_cd = (m_lane == NL - 1);
                m_lane = (m_lane + 1) % NL;
            end
        end else if (m_el == m_glen - 1 && c[m_lane] && m_ext < MX) begin
            m_glen += ET; m_ext++; m_el++;
        end else if (m_el == m_glen + YT + AT - 1) begin
            m_serving = 0;
            m_cd = (m_lane == NL - 1);
            m_lane = (m_lane + 1) % NL;
        end else begin
            m_el++;
        end
    endtask

    function automatic logic [27:0] model_exp();
        if (!m_serving)            return pack_exp(0, m_lane, 0, 0, m_ext, m_cd);
        if (m_el < GT)             return pack_exp(1, m_lane, 2*m_lane+1, GT-1-m_el, m_ext, m_cd);
        if (m_el < m_glen)         return pack_exp(2, m_lane, 2*m_lane+1, m_glen-1-m_el, m_ext, m_cd);
        if (m_el < m_glen + YT)    return pack_exp(3, m_lane, 2*m_lane+2, m_glen+YT-1-m_el, m_ext, m_cd);
        return pack_exp(4, m_lane, 0, m_glen+YT+AT-1-m_el, m_ext, m_cd);
    endfunction

    initial begin
        int exp3[21] = '{1,1,1,1,2,2,0,3,3,3,3,4,4,0,5,5,5,5,6,6,0};
        int cnt7, cnt8, k;
        bit found;

        //            rst start cong     ph lane sig tmr ext cd
        tbl[0]  = '{0, 4'h0, 4'h0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 4'h0, 4'h0,  0, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 4'h0, 4'h0,  0, 2, 0, 0, 0, 0};
        tbl[3]  = '{1, 4'h0, 4'h0,  0, 3, 0, 0, 0, 0};
        tbl[4]  = '{1, 4'h0, 4'h0,  0, 0, 0, 0, 0, 1};
        tbl[5]  = '{1, 4'h0, 4'h0,  0, 1, 0, 0, 0, 0};
        tbl[6]  = '{1, 4'h1, 4'h0,  0, 2, 0, 0, 0, 0};
        tbl[7]  = '{1, 4'h1, 4'h0,  0, 3, 0, 0, 0, 0};
        tbl[8]  = '{1, 4'h1, 4'h0,  0, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 4'h1, 4'h0,  1, 0, 1, 3, 0, 0};
        tbl[10] = '{1, 4'h1, 4'h0,  1, 0, 1, 2, 0, 0};
        tbl[11] = '{1, 4'h1, 4'h0,  1, 0, 1, 1, 0, 0};
        tbl[12] = '{1, 4'h1, 4'h0,  1, 0, 1, 0, 0, 0};
        tbl[13] = '{1, 4'h1, 4'h0,  3, 0, 2, 1, 0, 0};
        tbl[14] = '{1, 4'h1, 4'h0,  3, 0, 2, 0, 0, 0};
        tbl[15] = '{1, 4'h1, 4'h0,  4, 0, 0, 0, 0, 0};
        tbl[16] = '{1, 4'h4, 4'h4,  0, 1, 0, 0, 0, 0};
        tbl[17] = '{1, 4'h4, 4'h4,  0, 2, 0, 0, 0, 0};
        tbl[18] = '{1, 4'h4, 4'h4,  1, 2, 5, 3, 0, 0};
        tbl[19] = '{1, 4'h4, 4'h4,  1, 2, 5, 2, 0, 0};
        tbl[20] = '{1, 4'h4, 4'h4,  1, 2, 5, 1, 0, 0};
        tbl[21] = '{1, 4'h4, 4'h4,  1, 2, 5, 0, 0, 0};
        tbl[22] = '{1, 4'h4, 4'h4,  2, 2, 5, 1, 1, 0};
        tbl[23] = '{1, 4'h4, 4'h4,  2, 2, 5, 0, 1, 0};
        tbl[24] = '{1, 4'h4, 4'h4,  2, 2, 5, 1, 2, 0};
        tbl[25] = '{1, 4'h4, 4'h4,  2, 2, 5, 0, 2, 0};
        tbl[26] = '{1, 4'h4, 4'h4,  3, 2, 6, 1, 2, 0};
        tbl[27] = '{1, 4'h4, 4'h4,  3, 2, 6, 0, 2, 0};
        tbl[28] = '{1, 4'h4, 4'h4,  4, 2, 0, 0, 2, 0};
        tbl[29] = '{1, 4'h4, 4'h4,  0, 3, 0, 0, 2, 0};
        tbl[30] = '{1, 4'h4, 4'h4,  0, 0, 0, 0, 2, 1};
        tbl[31] = '{1, 4'h4, 4'h4,  0, 1, 0, 0, 2, 0};

        rst_n = 1'b0;
        bus.start_sense = '0;
        bus.cong_sense = '0;
        bus3.start_sense = '0;
        bus3.cong_sense = '0;

        for (int i = 0; i < 32; i++) begin
            step(tbl[i].rst_n, tbl[i].start, tbl[i].cong);
            check($sformatf("table[%0d]", i),
                  pack_exp(tbl[i].ph, tbl[i].lane, tbl[i].light, tbl[i].timer, tbl[i].ext, tbl[i].cd));
        end

        // Lane 3: congestion present on every green cycle except the decision one.
        step(0, 4'h0, 4'h0);
        found = 0;
        for (k = 0; k < 20 && !found; k++) begin
            step(1, 4'h8, 4'h0);
            found = (bus.light_signal == 7);
        end
        check_val("lane3_green_seen", int'(found), 1);
        cnt7 = 1;
        for (k = 0; k < 20 && bus.light_signal == 7; k++) begin
            step(1, 4'h8, (bus.timer != 0) ? 4'h8 : 4'h0);
            if (bus.light_signal == 7) cnt7++;
        end
        cnt8 = 0;
        for (k = 0; k < 20 && bus.light_signal == 8; k++) begin
            cnt8++;
            step(1, 4'h8, 4'h0);
        end
        check_val("lane3_green_len", cnt7, 4);
        check_val("lane3_yellow_len", cnt8, 2);

        // Reset while lane 1 is in GREEN with timer 2.
        step(0, 4'h0, 4'h0);
        found = 0;
        for (k = 0; k < 20 && !found; k++) begin
            step(1, 4'h2, 4'h0);
            found = (bus.phase == 1 && bus.active_lane == 1 && bus.timer == 2);
        end
        check_val("lane1_green_t2_seen", int'(found), 1);
        step(0, 4'h2, 4'h0);
        check("reset_mid_green", pack_exp(0, 0, 0, 0, 0, 0));

        // A reset pulse that falls entirely between edges has no effect.
        found = 0;
        for (k = 0; k < 20 && !found; k++) begin
            step(1, 4'h2, 4'h0);
            found = (bus.phase == 1 && bus.active_lane == 1 && bus.timer == 2);
        end
        check_val("lane1_green_t2_again", int'(found), 1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step(1, 4'h2, 4'h0);
        check("rst_glitch_no_edge", pack_exp(1, 1, 3, 1, 0, 0));

        // Three lanes, no all-red, no extension, everything requesting.
        bus3.start_sense = 3'b111;
        bus3.cong_sense  = 3'b111;
        step(0, 4'h0, 4'h0);
        for (int i = 0; i < 21; i++) begin
            int ph;
            ph = (exp3[i] == 0) ? 0 : ((exp3[i] % 2 == 1) ? 1 : 3);
            step(1, 4'h0, 4'h0);
            check_val($sformatf("dut3_seq[%0d]", i),
                      int'({bus3.phase, bus3.light_signal, bus3.cycle_done}),
                      (ph << 4) | (exp3[i] << 1) | ((i == 20) ? 1 : 0));
        end

        // Random sensors and occasional resets against the timeline model.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            logic [3:0] s, c;
            r = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            for (int b = 0; b < 4; b++) begin
                s[b] = ($urandom_range(0, 9) < 3);
                c[b] = ($urandom_range(0, 9) < 6);
            end
            model_step(r, s, c);
            step(r, s, c);
            check($sformatf("random[%0d]", i), model_exp());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
